// File: rtl/search_block_scheduler.sv
// search_block_scheduler: raster walk over the block grid issuing vertically cropped search-window row requests
module search_block_scheduler #(
  parameter int blk_h      = 16,
  parameter int blk_w      = 16,
  parameter int third_h    = 480,
  parameter int third_w    = 640,
  parameter int srch_blk_h = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        req_ready,
  input  logic        blk_result_valid,
  output logic        req_valid,
  output logic [15:0] req_blk_index,
  output logic [15:0] req_coords,
  output logic        req_last,
  output logic        busy,
  output logic        frame_done
);
  localparam logic [7:0] min_row      = 8'((srch_blk_h - blk_h) / 2);
  localparam logic [7:0] max_row      = 8'(srch_blk_h - (srch_blk_h - blk_h) / 2 - 1);
  localparam logic [7:0] full_last    = 8'(srch_blk_h - 1);
  localparam logic [5:0] last_blk_row = 6'(third_h / blk_h - 1);
  localparam logic [5:0] last_blk_col = 6'(third_w / blk_w - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t     state;
  logic [5:0] blk_row, blk_col, nb_row, nb_col;
  logic [7:0] row, cur_last, nb_first, nb_last;
  logic       last_col, frame_end, load;
  // next block to load: the origin when starting, otherwise the raster successor
  always_comb begin
    last_col  = blk_col == last_blk_col;
    frame_end = last_col && blk_row == last_blk_row;
    nb_row    = state == IDLE ? 6'd0 : last_col ? blk_row + 6'd1 : blk_row;
    nb_col    = state == IDLE || last_col ? 6'd0 : blk_col + 6'd1;
    cur_last  = blk_row == last_blk_row ? max_row : full_last;
    nb_first  = nb_row == 6'd0 ? min_row : 8'd0;
    nb_last   = nb_row == last_blk_row ? max_row : full_last;
    load      = (state == IDLE && start) || (state == WAIT && blk_result_valid && !frame_end);
  end
  // state machine with registered request outputs held stable while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      blk_row       <= 6'd0;
      blk_col       <= 6'd0;
      row           <= 8'd0;
      req_valid     <= 1'b0;
      req_blk_index <= 16'h0000;
      req_coords    <= 16'h0000;
      req_last      <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        state         <= ISSUE;
        blk_row       <= nb_row;
        blk_col       <= nb_col;
        row           <= nb_first;
        req_valid     <= 1'b1;
        req_blk_index <= {4'h0, nb_row, nb_col};
        req_coords    <= {nb_first, 8'h00};
        req_last      <= nb_first == nb_last;
        busy          <= 1'b1;
      end else begin
        case (state)
          ISSUE: if (req_ready) begin
            if (row == cur_last) begin
              state     <= WAIT;
              req_valid <= 1'b0;
              req_last  <= 1'b0;
            end else begin
              row        <= row + 8'd1;
              req_coords <= {row + 8'd1, 8'h00};
              req_last   <= row + 8'd1 == cur_last;
            end
          end
          WAIT: if (blk_result_valid) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_search_block_scheduler.sv
// tb_search_block_scheduler: scoreboard bench for default and single-block-row configurations
module tb_search_block_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_rst = 1'b1, a_start = 1'b0, a_start_mid = 1'b0, a_ready = 1'b1, a_resp = 1'b0, a_spur = 1'b0, a_en = 1'b1;
  logic a_req_valid, a_req_last, a_busy, a_frame_done;
  logic [15:0] a_req_blk_index, a_req_coords;
  logic b_rst = 1'b1, b_start = 1'b0, b_ready = 1'b1, b_resp = 1'b0;
  logic b_req_valid, b_req_last, b_busy, b_frame_done;
  logic [15:0] b_req_blk_index, b_req_coords;
  search_block_scheduler dut_a (
    .clk(clk), .reset(a_rst), .start(a_start | a_start_mid), .req_ready(a_ready),
    .blk_result_valid(a_resp | a_spur), .req_valid(a_req_valid), .req_blk_index(a_req_blk_index),
    .req_coords(a_req_coords), .req_last(a_req_last), .busy(a_busy), .frame_done(a_frame_done)
  );
  search_block_scheduler #(.third_h(16)) dut_b (
    .clk(clk), .reset(b_rst), .start(b_start), .req_ready(b_ready),
    .blk_result_valid(b_resp), .req_valid(b_req_valid), .req_blk_index(b_req_blk_index),
    .req_coords(b_req_coords), .req_last(b_req_last), .busy(b_busy), .frame_done(b_frame_done)
  );
  int total = 0, passes = 0, phase = 0;
  int a_exp_done = 0, a_frames = 0, a_n147 = 0, b_exp_done = 0, b_frames = 0, b_beats = 0;
  bit b_done = 0, spur_done = 0, a_stalled = 0;
  logic [32:0] a_q[$], b_q[$], a_held;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h expected=%h", n, act, exp);
  endtask
  task automatic push_frame(input bit to_b, input int nbr, input int nbc);
    for (int r = 0; r < nbr; r++)
      for (int c = 0; c < nbc; c++) begin
        int f, l;
        f = r == 0 ? 4 : 0;
        l = r == nbr - 1 ? 19 : 23;
        for (int w = f; w <= l; w++) begin
          logic [32:0] b;
          b = {4'h0, 6'(r), 6'(c), 8'(w), 8'h00, w == l};
          if (to_b) b_q.push_back(b);
          else a_q.push_back(b);
        end
      end
  endtask
  // monitor A: scoreboard pops, stall stability, frame_done legality
  initial forever begin
    @(negedge clk);
    if (a_rst) a_stalled = 0;
    else begin
      if (a_req_valid && a_stalled) chk("a_stall_hold", {a_req_blk_index, a_req_coords, a_req_last}, a_held);
      a_stalled = a_req_valid && !a_ready;
      a_held = {a_req_blk_index, a_req_coords, a_req_last};
      if (a_req_valid && a_ready) begin
        if (a_q.size() == 0) begin
          total++;
          $display("FAIL a_beat actual=%h required=none", {a_req_blk_index, a_req_coords, a_req_last});
        end else chk("a_beat", {a_req_blk_index, a_req_coords, a_req_last}, a_q.pop_front());
        if (a_req_blk_index == 16'h0147) a_n147++;
      end
      if (a_frame_done) begin
        chk("a_frame_done", {a_exp_done > 0, a_q.size() == 0}, 2'b11);
        a_exp_done--;
        a_frames++;
      end
    end
  end
  // monitor B
  initial forever begin
    @(negedge clk);
    if (!b_rst) begin
      if (b_req_valid && b_ready) begin
        b_beats++;
        if (b_q.size() == 0) begin
          total++;
          $display("FAIL b_beat actual=%h required=none", {b_req_blk_index, b_req_coords, b_req_last});
        end else chk("b_beat", {b_req_blk_index, b_req_coords, b_req_last}, b_q.pop_front());
      end
      if (b_frame_done) begin
        chk("b_frame_done", {b_exp_done > 0, b_q.size() == 0}, 2'b11);
        b_exp_done--;
        b_frames++;
      end
    end
  end
  // engine models: result two cycles after the last row is accepted
  initial forever begin
    @(negedge clk);
    if (a_req_valid && a_ready && a_req_last && !a_rst) begin
      @(posedge clk); @(posedge clk); #1 if (a_en) a_resp = 1'b1;
      @(posedge clk); #1 a_resp = 1'b0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (b_req_valid && b_ready && b_req_last && !b_rst) begin
      @(posedge clk); @(posedge clk); #1 b_resp = 1'b1;
      @(posedge clk); #1 b_resp = 1'b0;
    end
  end
  // random backpressure only while block (5,7) is being issued
  initial forever begin
    @(posedge clk); #1;
    a_ready = (a_req_valid && a_req_blk_index == 16'h0147) ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  // stray result pulse and mid-frame start during ISSUE of block (0,3)
  initial forever begin
    @(negedge clk);
    if (phase == 2 && !spur_done && a_req_valid && a_req_blk_index == 16'h0003 && a_req_coords[15:8] == 8'd8) begin
      spur_done = 1;
      a_spur = 1'b1;
      a_start_mid = 1'b1;
      @(negedge clk);
      a_spur = 1'b0;
      a_start_mid = 1'b0;
    end
  end
  // configuration B: single block row, rows 4..19 only
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("b_reset_outputs", {b_req_valid, b_req_blk_index, b_req_coords, b_req_last, b_busy, b_frame_done}, 0);
    @(posedge clk); #1 b_rst = 1'b0;
    push_frame(1, 1, 40);
    b_exp_done = 1;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    n = 0;
    while (b_frames == 0 && n < 3000) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("b_frame_count", b_frames, 1);
    chk("b_beat_count", b_beats, 640);
    chk("b_queue_empty", b_q.size(), 0);
    b_done = 1;
  end
  // configuration A: reset mid-pass, then a full pass with stalls and ignored inputs
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("a_reset_outputs", {a_req_valid, a_req_blk_index, a_req_coords, a_req_last, a_busy, a_frame_done}, 0);
    @(posedge clk); #1 a_rst = 1'b0;
    push_frame(0, 30, 40);
    phase = 1;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(a_req_valid && a_ready && a_req_last && a_req_blk_index == 16'h00C2) && n < 10000);
    chk("a_reach_block_3_2", n < 10000, 1);
    @(posedge clk); #1 a_en = 1'b0; a_rst = 1'b1;
    a_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("a_reset_mid_outputs", {a_req_valid, a_req_blk_index, a_req_coords, a_req_last, a_busy, a_frame_done}, 0);
    end
    @(posedge clk); #1 a_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 a_en = 1'b1;
    @(negedge clk);
    chk("a_idle_after_reset", {a_busy, a_req_valid}, 0);
    push_frame(0, 30, 40);
    a_exp_done = 1;
    phase = 2;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    @(negedge clk);
    chk("a_first_request", {a_req_valid, a_req_blk_index, a_req_coords, a_req_last}, {1'b1, 16'h0000, 16'h0400, 1'b0});
    n = 0;
    while (!a_frame_done && n < 40000) begin @(negedge clk); n++; end
    chk("a_frame_timeout", a_frame_done, 1);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_start_in_done_ignored", {a_busy, a_req_valid}, 0);
    chk("a_frame_count", a_frames, 1);
    chk("a_block_5_7_beats", a_n147, 24);
    chk("a_queue_empty", a_q.size(), 0);
    chk("a_spur_injected", spur_done, 1);
    n = 0;
    while (!b_done && n < 5000) begin @(negedge clk); n++; end
    chk("b_finished", b_done, 1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/search_block_scheduler.md
Name: search_block_scheduler

Overview:
- Sequences the block-matching datapath over one image third: walks the block grid in raster order and, for each block, issues one request per search-window row, as a (block index, row coordinate) pair.
- Applies vertical cropping at source: on the first and last block rows, search-window rows that fall outside the image are never issued, so the downstream cropper sees only valid rows.
- Waits for the matching engine to report each block finished before starting the next.

Parameters:
- blk_h, 16, block height in pixels
- blk_w, 16, block width in pixels
- third_h, 480, image-third height in pixels; must be a multiple of blk_h
- third_w, 640, image-third width in pixels; must be a multiple of blk_w
- srch_blk_h, 24, search-window height in rows; srch_blk_h >= blk_h, and (srch_blk_h - blk_h) even

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame pass when idle
- req_ready  in  1  downstream accepts the current request
- blk_result_valid  in  1  one-cycle pulse; engine has finished the current block
- req_valid  out  1  request valid
- req_blk_index  out  16  {4'b0, blk_row[5:0], blk_col[5:0]}
- req_coords  out  16  {search_row[7:0], 8'h00}
- req_last  out  1  current request is the final row of its block
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse after the last block's result

Behaviour:
- Derived constants:
  - min_row = (srch_blk_h - blk_h)/2
  - max_row = srch_blk_h - min_row - 1
  - last_blk_row = third_h/blk_h - 1
  - last_blk_col = third_w/blk_w - 1
- Reset: all outputs 0, state IDLE, all counters 0.
- Row range for a block:
  - first_row = min_row if blk_row == 0, else 0.
  - last_row = max_row if blk_row == last_blk_row, else srch_blk_h - 1.
  - If both conditions hold (single block row), both limits apply.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 -> ISSUE with blk_row=0, blk_col=0, row=first_row.
  - req_valid rises on the cycle after start.
- ISSUE:
  - req_valid=1; req_blk_index, req_coords and req_last are registered and held stable while req_ready=0.
  - On req_valid && req_ready: if row == last_row -> WAIT (req_valid=0 next cycle); else row+1.
  - req_last = (row == last_row).
- WAIT:
  - req_valid=0.
  - On blk_result_valid: if blk_row == last_blk_row and blk_col == last_blk_col -> DONE.
  - Otherwise advance the block. If blk_col == last_blk_col, set blk_col=0 and blk_row+1; else blk_col+1. Then load row=first_row for the new block and go to ISSUE.
- DONE: frame_done=1 for exactly one cycle -> IDLE.
- Ignored inputs:
  - blk_result_valid in IDLE, ISSUE or DONE is ignored; no queuing.
  - start outside IDLE is ignored, including start in the DONE cycle.
- Timing:
  - Throughput is one request per cycle while req_ready=1.
  - At least one idle cycle separates blocks (the WAIT state).
- Reset asserted mid-operation: return immediately to IDLE with outputs 0; no frame_done is emitted.
- Widths:
  - row counter is 8 bits; block counters are 6 bits each.
  - req_blk_index[15:12] = 0; req_coords[7:0] = 0.

Test Plan:
- Defaults, start, req_ready=1, engine answers 2 cycles after each req_last -> block 0 issues rows 4..23 (20 beats, req_last on row 23). Block (0,1) issues the same rows. Block (1,0) (req_blk_index=0x0040) issues rows 0..23. Block (29,39) (req_blk_index=0x0767) issues rows 0..19. frame_done pulses once, after 1200 results.
- req_ready toggled randomly during block (5,7) -> no request dropped or duplicated; req_blk_index=0x0147 and req_coords held stable across every stall; exactly 24 accepted beats.
- blk_result_valid pulsed during ISSUE, and start pulsed mid-frame -> both ignored; the block sequence is unchanged.
- third_h=16, srch_blk_h=24 -> every block issues only rows 4..19 (16 beats); frame_done follows the result for block (0,39).
- Reset asserted during WAIT of block (3,2), then start -> outputs 0 during reset; the first request after start is block 0x0000, row 4; no frame_done is seen before the new pass completes.
